// File: rtl/m_store_buffer.sv
// Write-combining store buffer: queues word-aligned M-stage stores, merges
// back-to-back stores to the same word and drains them over a req/ack bus.
module m_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [31:0]              st_addr,
  input  logic [3:0]               st_byteen,
  input  logic [31:0]              st_wdata,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_addr,
  output logic                     stall,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  output logic [3:0]               mem_byteen,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       head_q, head_d;
  logic [PW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DEPTH-1:0]    vld_q, vld_d;
  logic [29:0]         ent_addr_q [DEPTH];
  logic [29:0]         ent_addr_d [DEPTH];
  logic [3:0]          ent_be_q   [DEPTH];
  logic [3:0]          ent_be_d   [DEPTH];
  logic [31:0]         ent_data_q [DEPTH];
  logic [31:0]         ent_data_d [DEPTH];
  logic                mem_req_q, mem_req_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [31:0]         mem_data_q, mem_data_d;

  logic [PW-1:0]       young;
  logic                st_qual;
  logic                young_inflight;
  logic                merge_hit;
  logic                full;
  logic                ld_hit;
  logic                do_merge;
  logic                do_push;
  logic                do_pop;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = ^{st_addr[1:0], ld_addr[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

  // Hazard detection and store acceptance
  always_comb begin
    young          = tail_q - PW'(1);
    st_qual        = st_valid && (st_byteen != 4'b0000);
    full           = (count_q == FULL_CNT);
    // The youngest entry is the head only when exactly one entry is queued.
    young_inflight = (state_q == S_REQ) && (young == head_q);
    merge_hit      = st_qual && (count_q != '0) &&
                     (ent_addr_q[young] == st_addr[31:2]) && !young_inflight;
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (ent_addr_q[i] == ld_addr[31:2])) ld_hit = 1'b1;
    end
    stall    = (st_qual && !merge_hit && full) || (ld_valid && ld_hit);
    do_merge = merge_hit && !stall;
    do_push  = st_qual && !merge_hit && !full && !stall;
    do_pop   = (state_q == S_REQ) && mem_ack;
  end

  always_comb begin
    ent_addr_d = ent_addr_q;
    ent_be_d   = ent_be_q;
    ent_data_d = ent_data_q;
    vld_d      = vld_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (do_merge) begin
      ent_be_d[young]   = ent_be_q[young] | st_byteen;
      ent_data_d[young] = merge_bytes(ent_data_q[young], st_wdata, st_byteen);
    end
    if (do_push) begin
      ent_addr_d[tail_q] = st_addr[31:2];
      ent_be_d[tail_q]   = st_byteen;
      ent_data_d[tail_q] = st_wdata;
      vld_d[tail_q]      = 1'b1;
      tail_d             = tail_q + PW'(1);
    end
    if (do_pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Drain FSM; the bus registers load from post-update entry contents so a
  // same-edge merge or push into the next head is never presented stale.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_be_d   = mem_be_q;
    mem_data_d = mem_data_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          mem_req_d  = 1'b1;
          mem_addr_d = {ent_addr_d[head_d], 2'b00};
          mem_be_d   = ent_be_d[head_d];
          mem_data_d = ent_data_d[head_d];
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          if (count_d != '0) begin
            mem_addr_d = {ent_addr_d[head_d], 2'b00};
            mem_be_d   = ent_be_d[head_d];
            mem_data_d = ent_data_d[head_d];
          end else begin
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      vld_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_be_q   <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      vld_q      <= vld_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      mem_be_q   <= mem_be_d;
      mem_data_q <= mem_data_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_addr_q <= ent_addr_d;
    ent_be_q   <= ent_be_d;
    ent_data_q <= ent_data_d;
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_byteen = mem_be_q;
  assign mem_wdata  = mem_data_q;
  assign count      = count_q;
  assign empty      = (count_q == '0);

endmodule

// File: tb/tb_m_store_buffer.sv
// Self-checking bench for m_store_buffer: directed scenarios plus random
// traffic, all checked against a queue-based model of the buffer.
module tb_m_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [3:0]  st_byteen;
  logic [31:0] st_wdata;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [2:0]  count;
  logic        empty;

  m_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_byteen(st_byteen), .st_wdata(st_wdata),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_byteen(mem_byteen), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  ent_t sent[$];
  ent_t rx[$];
  bit   busy;
  bit   acc_last;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = be[b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  // One clock: compare outputs at the falling edge, advance the model,
  // then return 1 time unit after the rising edge.
  task automatic cycle();
    bit   qual, merge, ldhit, exp_stall, ack;
    int   sz;
    ent_t e;
    @(negedge clk);
    sz    = q.size();
    qual  = st_valid && (st_byteen != 4'b0000);
    merge = qual && (sz > 0) && (q[sz-1].addr[31:2] == st_addr[31:2]) && !(busy && sz == 1);
    ldhit = 1'b0;
    foreach (q[i]) if (ld_valid && q[i].addr[31:2] == ld_addr[31:2]) ldhit = 1'b1;
    exp_stall = (qual && !merge && sz == DEPTH) || ldhit;
    check("stall", {31'd0, stall}, {31'd0, exp_stall});
    check("mem_req", {31'd0, mem_req}, {31'd0, busy});
    check("count", {29'd0, count}, sz);
    check("empty", {31'd0, empty}, {31'd0, sz == 0});
    if (busy) begin
      check("mem_addr", mem_addr, q[0].addr);
      check("mem_byteen", {28'd0, mem_byteen}, {28'd0, q[0].be});
      check("mem_wdata", mem_wdata & lane_mask(q[0].be), q[0].data & lane_mask(q[0].be));
    end
    ack = busy && mem_ack;
    if (ack) begin
      e.addr = mem_addr; e.be = mem_byteen; e.data = mem_wdata & lane_mask(mem_byteen);
      rx.push_back(e);
    end
    acc_last = 1'b0;
    if (!exp_stall && merge) begin
      e = q[sz-1];
      e.be = e.be | st_byteen;
      for (int b = 0; b < 4; b++) if (st_byteen[b]) e.data[b*8 +: 8] = st_wdata[b*8 +: 8];
      q[sz-1] = e;
      acc_last = 1'b1;
    end else if (!exp_stall && qual && sz < DEPTH) begin
      e.addr = {st_addr[31:2], 2'b00}; e.be = st_byteen; e.data = st_wdata;
      q.push_back(e);
      sent.push_back(e);
      acc_last = 1'b1;
    end
    if (ack) begin
      void'(q.pop_front());
      busy = (q.size() > 0);
    end else if (!busy) begin
      busy = (sz > 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_st(input logic v, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    st_valid = v; st_addr = a; st_byteen = be; st_wdata = d;
  endtask

  task automatic drain();
    int guard;
    set_st(1'b0, 32'h0, 4'h0, 32'h0);
    ld_valid = 1'b0;
    guard = 0;
    while ((q.size() > 0 || busy) && guard < 50) begin
      mem_ack = 1'b1;
      cycle();
      guard++;
    end
    mem_ack = 1'b0;
    if (guard >= 50) check("drain_timeout", 32'd1, 32'd0);
    check("drained_empty", {31'd0, empty}, 32'd1);
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    set_st(1'b1, 32'h44, 4'hF, 32'h1234_5678);
    ld_valid = 1'b1; ld_addr = 32'h44; mem_ack = 1'b1;
    #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    set_st(1'b0, 32'h0, 4'h0, 32'h0);
    ld_valid = 1'b0; mem_ack = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    busy = 1'b0;

    // Single store, held request, then ack
    set_st(1'b1, 32'h10, 4'b0011, 32'h0000_BEEF);
    cycle();
    set_st(1'b0, 32'h0, 4'h0, 32'h0);
    cycle();
    check("t1_req", {31'd0, mem_req}, 32'd1);
    check("t1_addr", mem_addr, 32'h10);
    check("t1_be", {28'd0, mem_byteen}, 32'h3);
    check("t1_data", mem_wdata, 32'h0000_BEEF);
    repeat (3) cycle();
    mem_ack = 1'b1;
    cycle();
    mem_ack = 1'b0;
    check("t1_count", {29'd0, count}, 32'd0);
    check("t1_req_off", {31'd0, mem_req}, 32'd0);

    // Merge while an older head is in flight
    set_st(1'b1, 32'h40, 4'hF, 32'hAAAA_AAAA);
    cycle();
    set_st(1'b0, 32'h0, 4'h0, 32'h0);
    cycle();
    set_st(1'b1, 32'h20, 4'b0001, 32'h0000_0011);
    cycle();
    set_st(1'b1, 32'h23, 4'b1000, 32'h4400_0000);
    cycle();
    set_st(1'b0, 32'h0, 4'h0, 32'h0);
    check("t2_count", {29'd0, count}, 32'd2);
    mem_ack = 1'b1;
    cycle();
    mem_ack = 1'b0;
    check("t2_addr", mem_addr, 32'h20);
    check("t2_be", {28'd0, mem_byteen}, 32'h9);
    check("t2_data", mem_wdata, 32'h4400_0011);
    drain();

    // Full buffer stalls a new store, even in the cycle of an ack
    for (int i = 0; i < 4; i++) begin
      set_st(1'b1, 32'h100 + 32'(i * 4), 4'hF, 32'hC0DE_0000 + 32'(i));
      cycle();
    end
    set_st(1'b1, 32'h200, 4'hF, 32'h0BAD_F00D);
    #1;
    check("t3_full_stall", {31'd0, stall}, 32'd1);
    cycle();
    check("t3_count_full", {29'd0, count}, 32'd4);
    mem_ack = 1'b1;
    #1;
    check("t3_ack_stall", {31'd0, stall}, 32'd1);
    cycle();
    mem_ack = 1'b0;
    #1;
    check("t3_unstall", {31'd0, stall}, 32'd0);
    cycle();
    check("t3_count_back", {29'd0, count}, 32'd4);
    drain();

    // Load hazard against a pending store
    set_st(1'b1, 32'h30, 4'hF, 32'h3030_3030);
    cycle();
    set_st(1'b0, 32'h0, 4'h0, 32'h0);
    ld_valid = 1'b1; ld_addr = 32'h32;
    #1;
    check("t4_ld_stall", {31'd0, stall}, 32'd1);
    repeat (3) cycle();
    mem_ack = 1'b1;
    #1;
    check("t4_ld_stall_ack", {31'd0, stall}, 32'd1);
    cycle();
    mem_ack = 1'b0;
    #1;
    check("t4_ld_clear", {31'd0, stall}, 32'd0);
    set_st(1'b1, 32'h30, 4'hF, 32'h3131_3131);
    ld_addr = 32'h34;
    cycle();
    set_st(1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    check("t4_ld_other", {31'd0, stall}, 32'd0);
    cycle();
    drain();

    // Ten stores through the ring with random acks
    sent.delete(); rx.delete();
    for (int i = 0; i < 10; i++) begin
      set_st(1'b1, 32'h1000 + 32'(i * 4), 4'($urandom_range(1, 15)), $urandom);
      guard = 0;
      do begin
        mem_ack = $urandom_range(0, 1);
        cycle();
        check("t5_count_max", {31'd0, count <= 3'd4}, 32'd1);
        guard++;
      end while (!acc_last && guard < 40);
      if (guard >= 40) check("t5_push_timeout", 32'd1, 32'd0);
    end
    drain();
    check("t5_rx_len", rx.size(), 32'd10);
    for (int i = 0; i < 10 && i < rx.size() && i < sent.size(); i++) begin
      check("t5_rx_addr", rx[i].addr, sent[i].addr);
      check("t5_rx_be", {28'd0, rx[i].be}, {28'd0, sent[i].be});
      check("t5_rx_data", rx[i].data, sent[i].data & lane_mask(sent[i].be));
    end

    // Reset in the middle of a transaction
    for (int i = 0; i < 3; i++) begin
      set_st(1'b1, 32'h500 + 32'(i * 4), 4'hF, 32'h5000_0000 + 32'(i));
      cycle();
    end
    set_st(1'b0, 32'h0, 4'h0, 32'h0);
    cycle();
    check("t6_pre_req", {31'd0, mem_req}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_req_async", {31'd0, mem_req}, 32'd0);
    check("t6_count", {29'd0, count}, 32'd0);
    check("t6_empty", {31'd0, empty}, 32'd1);
    q.delete(); busy = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) cycle();

    // Random traffic over a few words to exercise merges and hazards
    for (int n = 0; n < 400; n++) begin
      set_st($urandom_range(0, 1), 32'h600 + 32'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), $urandom);
      ld_valid = $urandom_range(0, 1);
      ld_addr  = 32'h600 + 32'($urandom_range(0, 19));
      mem_ack  = ($urandom_range(0, 2) == 0);
      cycle();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
